seven_seg_scan: RTL and testbench
=================================

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, giving clk cycles per digit slot (legal range >=2).
REQ-002 The block SHALL have parameter BLINK_DIV, default 25000000, giving clk cycles per blink half-period (legal range >=2).

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-005 The block SHALL have ports minutes_top_digit, minutes_bot_digit, seconds_top_digit and seconds_bot_digit, each input, 4, BCD digits from the stopwatch counter.
REQ-006 The block SHALL have port adj, input, 1; 1 selects adjust mode, in which the selected pair blinks.
REQ-007 The block SHALL have port sel, input, 1; 0 selects the minutes pair and 1 selects the seconds pair for blinking.
REQ-008 The block SHALL have port an, output, 4, active-low anode enables, with an[3] driving minutes_top and an[0] driving seconds_bot.
REQ-009 The block SHALL have port seg, output, 8, active-low cathodes ordered {dp,g,f,e,d,c,b,a}, and SHALL drive dp (seg[7]) to 1 at all times.

Function
REQ-010 The refresh prescaler SHALL count 0..REFRESH_DIV-1, assert scan_tick for one cycle when count==REFRESH_DIV-1, and then return to 0.
REQ-011 The 2-bit slot index SHALL increment on scan_tick and wrap from 3 to 0.
REQ-012 On a scan_tick with index==3, all four input digits SHALL be captured into a snapshot register. Slots 0-3 of the following frame SHALL display that snapshot, so there is no tearing within a frame.
REQ-013 an and seg SHALL be registered and SHALL reflect the current index and snapshot one clk after the index changes.
REQ-014 In the slot for index i, an SHALL equal a one-cold pattern with bit i low; all other bits SHALL be high.
REQ-015 The decode SHALL be active-low: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex seg values).
REQ-016 Any digit value from 10 to 15 SHALL display a dash, seg=BF, and SHALL cause no other side effect.
REQ-017 The blink counter SHALL count 0..BLINK_DIV-1 and toggle blink_off at the terminal count, but only while adj=1.
REQ-018 While adj=0, the blink counter SHALL be held at 0 and blink_off held at 0, so every entry into adjust mode starts with a full visible half-period.
REQ-019 When adj=1 and blink_off=1, the slots of the selected pair SHALL output an=1111 and seg=FF. The selected pair is indices 3,2 when sel=0 and indices 1,0 when sel=1. Other slots SHALL be unaffected.
REQ-020 A change of sel while adj=1 SHALL take effect on the next output register update and SHALL NOT reset the blink counter.
REQ-021 The prescaler, index and snapshot SHALL run identically regardless of adj or sel.
REQ-022 If the terminal counts of scan and blink fall on the same cycle, both events SHALL be applied in that cycle, with no priority between them.

Reset
REQ-023 While rst=0 at a clk edge, the following SHALL be cleared: prescaler=0, index=0, snapshot=all zeros, blink counter=0, blink_off=0, an=1111, seg=FF.
REQ-024 On the first edge after rst returns to 1, outputs SHALL update to an=1110 and seg=C0, which is the snapshot digit 0 in slot 0.
REQ-025 Reset asserted mid-frame or mid-blink SHALL abandon all in-progress counts, with no partial-frame output after reset release.
REQ-026 The block SHALL produce no X on an or seg from the first post-reset edge onward.

Verification
REQ-027 The bench SHALL run with REFRESH_DIV=4 and BLINK_DIV=8 and cover the following scenarios.
REQ-028 Reset: hold rst=0 for 3 cycles with inputs 1,2,3,4 -> an=1111 and seg=FF during reset; an=1110 and seg=C0 on the first cycle after release. Digits 4,3,2,1 SHALL appear starting in the second frame.
REQ-029 Scan order: inputs 1,2,3,4 held -> slots show seg=99/an=1110, B0/1101, A4/1011, F9/0111, each 4 cycles long, repeating.
REQ-030 Snapshot: change seconds_bot from 4 to 7 during slot 1 -> slot 0 shows 99 until the next frame, then F8.
REQ-031 Invalid BCD: minutes_top=12 -> slot 3 seg=BF; other slots remain correct.
REQ-032 Blink: adj=1 and sel=0 -> slots 3 and 2 are blank (an=1111, seg=FF) for alternating 8-cycle windows while slots 1 and 0 are unaffected; sel=1 moves the blanking to slots 1 and 0.
REQ-033 Blink restart: drop adj while blink_off=1, then reassert it -> the display is visible for a full 8 cycles before the first blank.

Source files
------------

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver for a stopwatch display.
// A frame-wide snapshot keeps a frame free of tearing. In adjust mode the selected digit pair blinks.
module seven_seg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] minutes_top_digit,
  input  logic [3:0] minutes_bot_digit,
  input  logic [3:0] seconds_top_digit,
  input  logic [3:0] seconds_bot_digit,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [RW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic          scan_tick;
  logic          blink_last;
  logic          blank_slot;
  logic [3:0]    cur_digit;

  always_comb begin
    scan_tick = (pre_q == REF_LAST);
    pre_d     = scan_tick ? '0 : pre_q + RW'(1);
    idx_d     = scan_tick ? idx_q + 2'd1 : idx_q;
    snap_d    = snap_q;
    // Capture at the end of slot 3 so the next frame shows one coherent time.
    if (scan_tick && idx_q == 2'd3) begin
      snap_d = {minutes_top_digit, minutes_bot_digit, seconds_top_digit, seconds_bot_digit};
    end
  end

  always_comb begin
    blink_last  = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d = '0;
    blink_off_d = 1'b0;
    if (adj) begin
      blink_cnt_d = blink_last ? '0 : blink_cnt_q + BW'(1);
      blink_off_d = blink_last ? ~blink_off_q : blink_off_q;
    end
  end

  always_comb begin
    cur_digit  = snap_q[{idx_q, 2'b00} +: 4];
    // sel=0 blanks slots 3,2 (minutes); sel=1 blanks slots 1,0 (seconds).
    blank_slot = adj && blink_off_q && (sel ? ~idx_q[1] : idx_q[1]);
    an_d       = 4'b1111;
    seg_d      = 8'hFF;
    if (!blank_slot) begin
      an_d[idx_q] = 1'b0;
      case (cur_digit)
        4'd0:    seg_d = 8'hC0;
        4'd1:    seg_d = 8'hF9;
        4'd2:    seg_d = 8'hA4;
        4'd3:    seg_d = 8'hB0;
        4'd4:    seg_d = 8'h99;
        4'd5:    seg_d = 8'h92;
        4'd6:    seg_d = 8'h82;
        4'd7:    seg_d = 8'hF8;
        4'd8:    seg_d = 8'h80;
        4'd9:    seg_d = 8'h90;
        default: seg_d = 8'hBF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q       <= '0;
      idx_q       <= 2'd0;
      snap_q      <= '0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 8'hFF;
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized bench for seven_seg_scan against an arithmetic model of scan position,
// frame snapshots and blink phase derived from elapsed cycle counts.
module tb_seven_seg_scan;
  localparam int R = 4;
  localparam int B = 8;

  logic       clk;
  logic       rst;
  logic [3:0] mt, mb, st, sb;
  logic       adj, sel;
  logic [3:0] an;
  logic [7:0] seg;

  int checks = 0;
  int errors = 0;

  // Model state: k = edges since reset release, m = consecutive adjust-mode edges.
  int         k;
  int         m;
  logic [3:0] snap [4];
  logic [7:0] dec_tab [16];

  seven_seg_scan #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst),
    .minutes_top_digit(mt), .minutes_bot_digit(mb),
    .seconds_top_digit(st), .seconds_bot_digit(sb),
    .adj(adj), .sel(sel), .an(an), .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advances one clock; returns what the outputs should hold after the edge.
  task automatic tick(output logic [3:0] ea, output logic [7:0] es);
    int  idx;
    bit  boff;
    bit  blank;
    if (!rst) begin
      ea = 4'b1111;
      es = 8'hFF;
    end else begin
      idx   = (k / R) % 4;
      boff  = ((m / B) % 2) == 1;
      blank = adj && boff && (sel ? (idx <= 1) : (idx >= 2));
      ea = 4'b1111;
      es = 8'hFF;
      if (!blank) begin
        ea[idx] = 1'b0;
        es      = dec_tab[snap[idx]];
      end
    end
    @(posedge clk);
    if (!rst) begin
      k = 0;
      m = 0;
      for (int i = 0; i < 4; i++) snap[i] = 4'd0;
    end else begin
      if ((k + 1) % (4 * R) == 0) begin
        snap[0] = sb; snap[1] = st; snap[2] = mb; snap[3] = mt;
      end
      k = k + 1;
      m = adj ? m + 1 : 0;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] ea;
    logic [7:0] es;
    mt = 4'd1; mb = 4'd2; st = 4'd3; sb = 4'd4; adj = 1'b0; sel = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(ea, es);
      checks++;
      if (an !== 4'b1111 || seg !== 8'hFF) begin
        errors++;
        $display("FAIL reset_hold an=%b seg=%h expected an=1111 seg=FF", an, seg);
      end
    end
    rst = 1'b1;
    tick(ea, es);
    checks++;
    if (an !== 4'b1110 || seg !== 8'hC0) begin
      errors++;
      $display("FAIL reset_release an=%b seg=%h expected an=1110 seg=C0", an, seg);
    end
    for (int i = 1; i < 16; i++) begin
      tick(ea, es);
      checks++;
      if (an !== ea || seg !== es) begin
        errors++;
        $display("FAIL reset_frame1 cyc=%0d an=%b seg=%h expected an=%b seg=%h", i, an, seg, ea, es);
      end
    end
  endtask

  task automatic test_scan_order();
    logic [3:0] ea;
    logic [7:0] es;
    logic [3:0] an_tab [4];
    logic [7:0] seg_tab [4];
    an_tab[0] = 4'b1110; seg_tab[0] = 8'h99;
    an_tab[1] = 4'b1101; seg_tab[1] = 8'hB0;
    an_tab[2] = 4'b1011; seg_tab[2] = 8'hA4;
    an_tab[3] = 4'b0111; seg_tab[3] = 8'hF9;
    for (int j = 0; j < 32; j++) begin
      tick(ea, es);
      checks++;
      if (an !== an_tab[(j / R) % 4] || seg !== seg_tab[(j / R) % 4]) begin
        errors++;
        $display("FAIL scan_order cyc=%0d an=%b seg=%h expected an=%b seg=%h",
                 j, an, seg, an_tab[(j / R) % 4], seg_tab[(j / R) % 4]);
      end
      checks++;
      if (an !== ea || seg !== es) begin
        errors++;
        $display("FAIL scan_model cyc=%0d an=%b seg=%h expected an=%b seg=%h", j, an, seg, ea, es);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [3:0] ea;
    logic [7:0] es;
    int         guard;
    guard = 0;
    while ((k % (4 * R)) != R + 1 && guard < 64) begin
      tick(ea, es);
      guard++;
    end
    sb = 4'd7;
    for (int j = 0; j < 40; j++) begin
      tick(ea, es);
      checks++;
      if (an !== ea || seg !== es) begin
        errors++;
        $display("FAIL snapshot cyc=%0d an=%b seg=%h expected an=%b seg=%h", j, an, seg, ea, es);
      end
    end
  endtask

  task automatic test_invalid_bcd();
    logic [3:0] ea;
    logic [7:0] es;
    mt = 4'd12;
    for (int j = 0; j < 48; j++) begin
      if (j == 24) begin
        mb = 4'($urandom_range(10, 15));
        st = 4'($urandom_range(0, 15));
      end
      tick(ea, es);
      checks++;
      if (an !== ea || seg !== es) begin
        errors++;
        $display("FAIL invalid_bcd cyc=%0d an=%b seg=%h expected an=%b seg=%h", j, an, seg, ea, es);
      end
    end
    mt = 4'd1; mb = 4'd2; st = 4'd3;
  endtask

  task automatic test_blink();
    logic [3:0] ea;
    logic [7:0] es;
    adj = 1'b1;
    sel = 1'b0;
    for (int j = 0; j < 128; j++) begin
      if (j == 64) sel = 1'b1;
      tick(ea, es);
      checks++;
      if (an !== ea || seg !== es) begin
        errors++;
        $display("FAIL blink sel=%0b cyc=%0d an=%b seg=%h expected an=%b seg=%h", sel, j, an, seg, ea, es);
      end
    end
  endtask

  task automatic test_blink_restart();
    logic [3:0] ea;
    logic [7:0] es;
    int         guard;
    adj   = 1'b1;
    sel   = 1'b0;
    guard = 0;
    while (((m / B) % 2) == 0 && guard < 64) begin
      tick(ea, es);
      guard++;
    end
    tick(ea, es);
    adj = 1'b0;
    for (int j = 0; j < 5; j++) tick(ea, es);
    adj = 1'b1;
    // The first 8 adjust cycles after re-entry must all be visible.
    for (int j = 0; j < 2 * B + 8; j++) begin
      tick(ea, es);
      checks++;
      if (j < B && an === 4'b1111) begin
        errors++;
        $display("FAIL blink_restart_visible cyc=%0d an=%b expected a lit slot", j, an);
      end
      checks++;
      if (an !== ea || seg !== es) begin
        errors++;
        $display("FAIL blink_restart cyc=%0d an=%b seg=%h expected an=%b seg=%h", j, an, seg, ea, es);
      end
    end
    adj = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [3:0] ea;
    logic [7:0] es;
    adj = 1'b1;
    for (int j = 0; j < 11; j++) tick(ea, es);
    rst = 1'b0;
    tick(ea, es);
    tick(ea, es);
    rst = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick(ea, es);
      checks++;
      if (an !== ea || seg !== es) begin
        errors++;
        $display("FAIL mid_reset cyc=%0d an=%b seg=%h expected an=%b seg=%h", j, an, seg, ea, es);
      end
    end
    adj = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] ea;
    logic [7:0] es;
    for (int j = 0; j < 2000; j++) begin
      if ($urandom_range(0, 15) == 0) begin
        mt = 4'($urandom); mb = 4'($urandom); st = 4'($urandom); sb = 4'($urandom);
      end
      if ($urandom_range(0, 40) == 0) adj = ~adj;
      if ($urandom_range(0, 20) == 0) sel = ~sel;
      rst = ($urandom_range(0, 250) != 0);
      tick(ea, es);
      checks++;
      if ($isunknown({an, seg}) || an !== ea || seg !== es) begin
        errors++;
        $display("FAIL random cyc=%0d an=%b seg=%h expected an=%b seg=%h", j, an, seg, ea, es);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    dec_tab[0] = 8'hC0; dec_tab[1] = 8'hF9; dec_tab[2] = 8'hA4; dec_tab[3] = 8'hB0;
    dec_tab[4] = 8'h99; dec_tab[5] = 8'h92; dec_tab[6] = 8'h82; dec_tab[7] = 8'hF8;
    dec_tab[8] = 8'h80; dec_tab[9] = 8'h90;
    for (int i = 10; i < 16; i++) dec_tab[i] = 8'hBF;
    k = 0;
    m = 0;
    for (int i = 0; i < 4; i++) snap[i] = 4'd0;
    rst = 1'b0;
    mt = 4'd0; mb = 4'd0; st = 4'd0; sb = 4'd0;
    adj = 1'b0; sel = 1'b0;

    test_reset();
    test_scan_order();
    test_snapshot();
    test_invalid_bcd();
    test_blink();
    test_blink_restart();
    test_mid_reset();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
